// File: rtl/crc_sched_pkg.sv
// Shared types and default parameters for the crc24a core scheduler.
package crc_sched_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_LEN_W   = 16;
    localparam int DEF_CRC_W   = 24;
    localparam int DEF_TIMEOUT = 4096;
    localparam int DEF_CNT_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_RESP  = 3'd3,
        ST_FLUSH = 3'd4
    } sched_state_e;

endpackage

// File: rtl/crc_core_scheduler_rr_arbiter.sv
// Purpose: round-robin pick of the first asserted request at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller gates the grant with its own accept condition.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int ID_W = $clog2(NUM_REQ);

    int pos;

    // Walk offsets from the farthest to the nearest so the nearest hit wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (req[pos]) begin
                idx = ID_W'(pos);
                any = 1'b1;
            end
        end
        gnt[idx] = any;
    end

endmodule

// File: rtl/crc_core_scheduler.sv
// Purpose: shares one ap_ctrl_hs crc24a core among NUM_REQ requesters, round-robin, with watchdog.
// Latency: grant->ap_start 1 cycle; ap_done->rsp_valid 1 cycle; single job outstanding.
// Backpressure: rsp held stable until rsp_ready; no new grant until the response is taken.
module crc_core_scheduler
    import crc_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int CRC_W   = DEF_CRC_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*LEN_W-1:0]   req_len,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       core_ap_start,
    output logic [LEN_W-1:0]           core_len,
    input  logic                       core_ap_ready,
    input  logic                       core_ap_done,
    input  logic                       core_ap_idle,
    input  logic [CRC_W-1:0]           core_ap_return,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [CRC_W-1:0]           rsp_crc,
    output logic                       rsp_timeout,
    output logic [CNT_W-1:0]           jobs_done,
    output logic [CNT_W-1:0]           jobs_timeout
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    sched_state_e        state, state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [WD_W-1:0]     wdog;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_any;
    logic                grant_en, grant, in_job, wd_expired, cap_done, cap_to, rsp_hs;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Reset is folded in so req_ready reads 0 while reset is held.
    assign grant_en   = (state == ST_IDLE) && core_ap_idle && reset;
    assign grant      = grant_en && arb_any;
    assign in_job     = (state == ST_START) || (state == ST_RUN);
    assign wd_expired = (wdog == WD_W'(TIMEOUT - 1));
    // ap_done takes priority over a coincident watchdog expiry.
    assign cap_done   = ((state == ST_START) && core_ap_ready && core_ap_done) ||
                        ((state == ST_RUN) && core_ap_done);
    assign cap_to     = in_job && !cap_done && wd_expired;
    assign rsp_hs     = (state == ST_RESP) && rsp_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant) state_nxt = ST_START;
            ST_START: begin
                if (cap_done || cap_to) state_nxt = ST_RESP;
                else if (core_ap_ready) state_nxt = ST_RUN;
            end
            ST_RUN:   if (cap_done || cap_to) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) state_nxt = rsp_timeout ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: if (core_ap_idle || core_ap_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = grant_en ? arb_gnt : '0;
        core_ap_start = (state == ST_START);
        rsp_valid     = (state == ST_RESP);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr       <= '0;
            wdog         <= '0;
            core_len     <= '0;
            rsp_id       <= '0;
            rsp_crc      <= '0;
            rsp_timeout  <= 1'b0;
            jobs_done    <= '0;
            jobs_timeout <= '0;
        end else begin
            if (grant) begin
                core_len <= req_len[int'(arb_idx)*LEN_W +: LEN_W];
                rsp_id   <= arb_idx;
                rr_ptr   <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
                wdog     <= '0;
            end else if (in_job) begin
                wdog <= wdog + WD_W'(1);
            end

            if (cap_done) begin
                rsp_crc     <= core_ap_return;
                rsp_timeout <= 1'b0;
            end else if (cap_to) begin
                rsp_crc     <= '0;
                rsp_timeout <= 1'b1;
            end

            if (rsp_hs) begin
                if (rsp_timeout) begin
                    if (jobs_timeout != '1) jobs_timeout <= jobs_timeout + CNT_W'(1);
                end else begin
                    if (jobs_done != '1) jobs_done <= jobs_done + CNT_W'(1);
                end
            end
        end
    end

`ifndef SYNTHESIS
    // A done pulse outside an active or flushing job means the core and scheduler disagree.
    done_in_window: assert property (@(posedge clock) disable iff (!reset)
        core_ap_done |-> (state inside {ST_START, ST_RUN, ST_FLUSH}));
`endif

endmodule

// File: tb/tb_crc_core_scheduler.sv
// Directed plus randomized checks of crc_core_scheduler against a job-level reference model.
module tb_crc_core_scheduler;

    localparam int NR = 4;
    localparam int LW = 16;
    localparam int CW = 24;
    localparam int TO = 16;
    localparam int CN = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*LW-1:0]  req_len = '0;
    logic [NR-1:0]     req_ready;
    logic              core_ap_start;
    logic [LW-1:0]     core_len;
    logic              core_ap_ready = 1'b0;
    logic              core_ap_done = 1'b0;
    logic              core_ap_idle = 1'b1;
    logic [CW-1:0]     core_ap_return = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_id;
    logic [CW-1:0]     rsp_crc;
    logic              rsp_timeout;
    logic [CN-1:0]     jobs_done;
    logic [CN-1:0]     jobs_timeout;

    int compared = 0;
    int mismatched = 0;

    // Behavioural core: ready/done timed from the first cycle ap_start is seen.
    int          rdy_dly = 0;
    int          done_dly = 0;
    bit          never_done = 1'b0;
    bit          abort_req = 1'b0;
    bit          busy = 1'b0;
    int          t = 0;
    logic [CW-1:0] ret_val = '0;

    // Job-level reference state.
    int exp_ptr = 0;
    int exp_done = 0;
    int exp_to = 0;
    int win_log[$];

    crc_core_scheduler #(
        .NUM_REQ(NR), .LEN_W(LW), .CRC_W(CW), .TIMEOUT(TO), .CNT_W(CN)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_len        (req_len),
        .req_ready      (req_ready),
        .core_ap_start  (core_ap_start),
        .core_len       (core_len),
        .core_ap_ready  (core_ap_ready),
        .core_ap_done   (core_ap_done),
        .core_ap_idle   (core_ap_idle),
        .core_ap_return (core_ap_return),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_crc        (rsp_crc),
        .rsp_timeout    (rsp_timeout),
        .jobs_done      (jobs_done),
        .jobs_timeout   (jobs_timeout)
    );

    always #5 clock = ~clock;

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            busy = 1'b0; t = 0;
            core_ap_ready = 1'b0; core_ap_done = 1'b0; core_ap_idle = 1'b1;
        end else begin
            core_ap_ready = 1'b0;
            core_ap_done  = 1'b0;
            if (abort_req) begin
                busy = 1'b0; core_ap_idle = 1'b1; abort_req = 1'b0;
            end else begin
                if (!busy && core_ap_start) begin
                    busy = 1'b1; t = 0; core_ap_idle = 1'b0;
                end else if (busy) begin
                    t++;
                end
                if (busy) begin
                    if (t == rdy_dly) core_ap_ready = 1'b1;
                    if (!never_done && t == done_dly) begin
                        core_ap_done = 1'b1; core_ap_return = ret_val;
                        busy = 1'b0; core_ap_idle = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic run_job(input logic [NR-1:0] mask, input bit hold, input int rd, input int dd,
                           input bit nd, input logic [CW-1:0] r, input int bp);
        int win;
        int n;
        logic [LW-1:0] lens [NR];
        logic [CW-1:0] exp_crc;
        win = -1;
        for (int k = 0; k < NR; k++)
            if (win < 0 && mask[(exp_ptr + k) % NR]) win = (exp_ptr + k) % NR;
        for (int i = 0; i < NR; i++) begin
            lens[i] = LW'($urandom);
            req_len[i*LW +: LW] = lens[i];
        end
        rdy_dly = rd; done_dly = dd; never_done = nd; ret_val = r;
        req_valid = mask;
        #1;
        n = 0;
        while (req_ready == '0 && n < 50) begin tick(); n++; end
        chk("grant_onehot", 64'(req_ready), 64'(1) << win);
        win_log.push_back(win);
        tick();
        if (!hold) req_valid = '0;
        chk("core_start", 64'(core_ap_start), 64'(1));
        chk("core_len", 64'(core_len), 64'(lens[win]));
        n = 1;
        while (!rsp_valid && n < 100) begin tick(); n++; end
        exp_crc = nd ? '0 : r;
        chk("rsp_latency", 64'(n), 64'(nd ? TO + 1 : dd + 2));
        chk("rsp_id", 64'(rsp_id), 64'(win));
        chk("rsp_crc", 64'(rsp_crc), 64'(exp_crc));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(nd));
        chk("rsp_start_low", 64'(core_ap_start), 64'(0));
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_valid", 64'(rsp_valid), 64'(1));
            chk("bp_id", 64'(rsp_id), 64'(win));
            chk("bp_crc", 64'(rsp_crc), 64'(exp_crc));
            chk("bp_timeout", 64'(rsp_timeout), 64'(nd));
            chk("bp_no_grant", 64'(req_ready), 64'(0));
            chk("bp_start_low", 64'(core_ap_start), 64'(0));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        if (nd) exp_to++; else exp_done++;
        exp_ptr = (win + 1) % NR;
        chk("rsp_dropped", 64'(rsp_valid), 64'(0));
        chk("jobs_done", 64'(jobs_done), 64'(exp_done));
        chk("jobs_timeout", 64'(jobs_timeout), 64'(exp_to));
        if (nd) begin
            req_valid = mask;
            for (int i = 0; i < 3; i++) begin
                chk("flush_no_grant", 64'(req_ready), 64'(0));
                tick();
            end
            abort_req = 1'b1;
            tick();
            tick();
        end
    endtask

    initial begin
        int n;
        int rd;
        req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_start", 64'(core_ap_start), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_jobs_done", 64'(jobs_done), 64'(0));
        chk("rst_jobs_timeout", 64'(jobs_timeout), 64'(0));
        req_valid = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        tick();

        // Contention from a freshly reset pointer.
        win_log.delete();
        for (int j = 0; j < 5; j++)
            run_job(4'b1111, 1'b1, 1, 4 + j, 1'b0, CW'($urandom), 0);
        for (int j = 0; j < 5; j++) chk("rr_order", 64'(win_log[j]), 64'(j % 4));

        run_job(4'b0001, 1'b0, 2, 10, 1'b0, 24'hABCDEF, 0);
        run_job(4'b0010, 1'b0, 1, 1, 1'b0, CW'($urandom), 0);
        run_job(4'b0100, 1'b0, 3, TO - 1, 1'b0, CW'($urandom), 1);
        run_job(4'b1000, 1'b0, 2, 0, 1'b1, CW'($urandom), 0);
        run_job(4'b0001, 1'b0, 100, 0, 1'b1, CW'($urandom), 2);
        run_job(4'b1111, 1'b1, 1, 5, 1'b0, CW'($urandom), 20);

        for (int j = 0; j < 16; j++) begin
            rd = $urandom_range(0, 3);
            run_job(NR'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), rd,
                    rd + int'($urandom_range(0, 9)), ($urandom_range(0, 4) == 0),
                    CW'($urandom), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a job, after moving the pointer off zero.
        rdy_dly = 1; never_done = 1'b1;
        req_valid = 4'b0010;
        #1;
        n = 0;
        while (req_ready == '0 && n < 50) begin tick(); n++; end
        chk("pre_reset_grant", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = 4'b1111;
        repeat (4) tick();
        chk("pre_reset_busy", 64'(jobs_done != 0), 64'(1));
        reset = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
        chk("mid_rst_start", 64'(core_ap_start), 64'(0));
        chk("mid_rst_core_len", 64'(core_len), 64'(0));
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("mid_rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("mid_rst_rsp_crc", 64'(rsp_crc), 64'(0));
        chk("mid_rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
        chk("mid_rst_jobs_done", 64'(jobs_done), 64'(0));
        chk("mid_rst_jobs_timeout", 64'(jobs_timeout), 64'(0));
        req_valid = '0;
        @(negedge clock);
        reset = 1'b1;
        tick();
        exp_ptr = 0; exp_done = 0; exp_to = 0;
        win_log.delete();
        run_job(4'b1111, 1'b0, 0, 3, 1'b0, CW'($urandom), 0);
        chk("post_reset_ptr", 64'(win_log[0]), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
